roi_stream_packer: RTL and testbench
====================================

ROI_STREAM_PACKER -- requirements
Module: roi_stream_packer

Interface
REQ-001 SHALL have parameter BIT_DATA, default 8, pixel width.
REQ-002 SHALL have parameter BIT_COORD, default 32, coordinate register width.
REQ-003 SHALL have parameter WIDTH, default 800, maximum frame width in pixels.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 4, buffer entries.
REQ-005 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port arst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port tdata_i  input  BIT_DATA  cropped ROI pixel from ROI cropper.
REQ-008 SHALL have port tvalid_i  input  1  pixel valid; no upstream backpressure.
REQ-009 SHALL have port tlast_i  input  1  last pixel of ROI frame.
REQ-010 SHALL have ports xy_0_i, xy_1_i  input  BIT_COORD  corner points, x in [25:16], y in [9:0].
REQ-011 SHALL have port m_tdata_o  output  BIT_DATA  output pixel.
REQ-012 SHALL have port m_tvalid_o  output  1  output valid.
REQ-013 SHALL have port m_tready_i  input  1  downstream ready.
REQ-014 SHALL have port m_tlast_o  output  1  end of ROI row.
REQ-015 SHALL have port m_tuser_o  output  2  bit0 start-of-frame, bit1 end-of-frame.
REQ-016 SHALL have port overflow_o  output  1  sticky dropped-pixel flag.

Function
REQ-017 SHALL push {tlast_i, tdata_i} into the FIFO when tvalid_i=1 and the FIFO is not full, or when full and a pop occurs the same cycle.
REQ-018 SHALL drop the pixel when tvalid_i=1, FIFO full and no pop that cycle, and set overflow_o=1 from the next cycle until reset.
REQ-019 SHALL pop when m_tvalid_o=1 and m_tready_i=1; m_tvalid_o SHALL equal FIFO not-empty.
REQ-020 SHALL present the FIFO head (show-ahead): a pixel pushed into an empty FIFO in cycle N appears on m_tvalid_o/m_tdata_o in cycle N+1.
REQ-021 SHALL hold m_tdata_o, m_tlast_o, m_tuser_o stable while m_tvalid_o=1 and m_tready_i=0.
REQ-022 SHALL keep an occupancy count 0..FIFO_DEPTH; simultaneous push and pop leaves it unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL run an output FSM with states SOF (next pop is frame start) and BODY.
REQ-024 In SOF, m_tuser_o[0]=1 on the head beat; on pop the FSM SHALL latch row width W=|x1-x0|+1 (10-bit x fields, 11-bit result) and go to BODY.
REQ-025 SHALL count popped beats in a column counter; m_tlast_o=1 when column = W-1 (using the latched W, or the live W in SOF), column then wraps to 0.
REQ-026 m_tuser_o[1] and m_tlast_o SHALL be 1 on a beat whose stored eof bit is set; its pop SHALL return the FSM to SOF and clear the column counter.
REQ-027 SHALL treat W=1 as every beat carrying m_tlast_o=1, including the SOF beat.
REQ-028 SHALL treat x field 0 or greater than WIDTH as W=WIDTH.
REQ-029 Coordinate changes SHALL affect only frames whose SOF beat pops after the change.

Reset
REQ-030 On arst_i=1 the block SHALL immediately empty the FIFO, set FSM to SOF, column to 0, overflow_o=0, m_tvalid_o=0, m_tlast_o=0, m_tuser_o=0, m_tdata_o=0.
REQ-031 Reset mid-frame SHALL discard buffered pixels; the first push after release is an SOF beat.
REQ-032 FIFO storage SHALL not require reset; only pointers, count, FSM and flags are reset.

Configuration
REQ-033 Macro ROI_PACK_OVF_CNT_EN defined SHALL add output ovf_cnt_o (16 bits), counting dropped pixels, saturating at 65535, reset to 0.
REQ-034 Without ROI_PACK_OVF_CNT_EN the port ovf_cnt_o and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-035 x0=10,x1=13,y0=5,y1=6, 8 pixels 1..8, m_tready_i=1 -> beats 1..8, tuser[0] on 1, tlast on 4 and 8, tuser[1] on 8.
REQ-036 Same ROI with m_tready_i=0 for 3 cycles mid-row -> no data loss, outputs stable while stalled, order 1..8.
REQ-037 FIFO_DEPTH=16, m_tready_i=0, 20 pixels -> 16 stored, overflow_o=1 from cycle after 17th, ovf_cnt_o=4 with macro.
REQ-038 x0=20,x1=17 (reversed) -> W=4, tlast every 4th beat.
REQ-039 arst_i pulse after 5 of 8 pixels buffered -> m_tvalid_o=0 immediately; next pixel emerges with tuser[0]=1.
REQ-040 x0=x1=7, 3 pixels with tlast_i on third -> every beat tlast=1, tuser[0] on first, tuser[1] on third.

Source files
------------

// File: rtl/roi_stream_packer.sv
// Show-ahead pixel FIFO with AXI-stream framing (SOF/EOF in tuser, tlast at ROI row end).
// Optional ROI_PACK_OVF_CNT_EN adds a saturating dropped-pixel counter on ovf_cnt_o.
module roi_stream_packer #(
  parameter int BIT_DATA   = 8,
  parameter int BIT_COORD  = 32,
  parameter int WIDTH      = 800,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [BIT_DATA-1:0]  tdata_i,
  input  logic                 tvalid_i,
  input  logic                 tlast_i,
  input  logic [BIT_COORD-1:0] xy_0_i,
  input  logic [BIT_COORD-1:0] xy_1_i,
  output logic [BIT_DATA-1:0]  m_tdata_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 m_tlast_o,
  output logic [1:0]           m_tuser_o,
  output logic                 overflow_o
`ifdef ROI_PACK_OVF_CNT_EN
  ,output logic [15:0]         ovf_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_SOF, ST_BODY} state_t;

  logic [BIT_DATA:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  state_t            r_state;
  logic [10:0]       r_col, r_w;

  logic              w_full, w_empty, w_pop, w_push, w_drop;
  logic [BIT_DATA:0] w_head;
  logic              w_head_eof;
  logic [9:0]        w_x0, w_x1, w_xdiff;
  logic [10:0]       w_w_live, w_w_eff;
  logic              w_col_end;
  logic              w_unused_xy;

  assign w_unused_xy = ^{xy_0_i, xy_1_i};

  always_comb begin
    w_full     = (r_count == CW'(FIFO_DEPTH));
    w_empty    = (r_count == '0);
    w_pop      = ~w_empty & m_tready_i;
    w_push     = tvalid_i & (~w_full | w_pop);
    w_drop     = tvalid_i & w_full & ~w_pop;
    w_head     = r_mem[r_rd_ptr];
    w_head_eof = w_head[BIT_DATA];
    w_x0       = xy_0_i[25:16];
    w_x1       = xy_1_i[25:16];
    w_xdiff    = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
    // Out-of-range corners fall back to a full-width row.
    if ((w_x0 == '0) || (w_x1 == '0) ||
        ({1'b0, w_x0} > 11'(WIDTH)) || ({1'b0, w_x1} > 11'(WIDTH)))
      w_w_live = 11'(WIDTH);
    else
      w_w_live = {1'b0, w_xdiff} + 11'd1;
    w_w_eff   = (r_state == ST_SOF) ? w_w_live : r_w;
    w_col_end = (r_col == (w_w_eff - 11'd1));
  end

  assign m_tvalid_o = ~w_empty;
  assign m_tdata_o  = w_empty ? '0 : w_head[BIT_DATA-1:0];
  assign m_tlast_o  = ~w_empty & (w_head_eof | w_col_end);
  assign m_tuser_o  = {~w_empty & w_head_eof, ~w_empty & (r_state == ST_SOF)};
  assign overflow_o = r_overflow;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {tlast_i, tdata_i};
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Row width is captured on the SOF pop so mid-frame coordinate edits are ignored.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_SOF;
      r_col   <= '0;
      r_w     <= '0;
    end else if (w_pop) begin
      if (w_head_eof) begin
        r_state <= ST_SOF;
        r_col   <= '0;
      end else begin
        if (r_state == ST_SOF) r_w <= w_w_live;
        r_state <= ST_BODY;
        r_col   <= w_col_end ? 11'd0 : r_col + 11'd1;
      end
    end
  end

`ifdef ROI_PACK_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                             r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end
  assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_roi_stream_packer.sv
// Directed bench for roi_stream_packer: expected beats are queued as pixels are driven
// and checked as they pop; also checks stalls, overflow timing and async reset.
module tb_roi_stream_packer;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [7:0]  tdata_i;
  logic        tvalid_i, tlast_i;
  logic [31:0] xy_0_i, xy_1_i;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o, m_tready_i, m_tlast_o;
  logic [1:0]  m_tuser_o;
  logic        overflow_o;
`ifdef ROI_PACK_OVF_CNT_EN
  logic [15:0] ovf_cnt_o;
`endif

  roi_stream_packer dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tlast_i(tlast_i),
    .xy_0_i(xy_0_i), .xy_1_i(xy_1_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tlast_o(m_tlast_o), .m_tuser_o(m_tuser_o), .overflow_o(overflow_o)
`ifdef ROI_PACK_OVF_CNT_EN
    ,.ovf_cnt_o(ovf_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       tlast;
    logic [1:0] tuser;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake pops one expected beat.
  always @(negedge clk_i) begin
    beat_t e;
    beat_t o;
    if (!arst_i && m_tvalid_o && m_tready_i) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_beat observed=%0h expected=none", {m_tlast_o, m_tuser_o, m_tdata_o});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o = {m_tlast_o, m_tuser_o, m_tdata_o};
        total++;
        assert (o === e) else begin
          bad++;
          $error("FAIL beat observed=%0h expected=%0h", o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
    xy_0_i = '0;
    xy_1_i = '0;
    xy_0_i[25:16] = 10'(x0);
    xy_0_i[9:0]   = 10'(y0);
    xy_1_i[25:16] = 10'(x1);
    xy_1_i[9:0]   = 10'(y1);
  endtask

  function automatic beat_t mk(input int i, input int n, input int w, input int d);
    beat_t b;
    b.tlast = (i == n - 1) || ((i % w) == w - 1);
    b.tuser = {i == n - 1, i == 0};
    b.data  = 8'(d);
    return b;
  endfunction

  task automatic send(input int n, input int first, input int w);
    for (int i = 0; i < n; i++) begin
      tick();
      tdata_i  = 8'(first + i);
      tvalid_i = 1'b1;
      tlast_i  = (i == n - 1);
      exp_q.push_back(mk(i, n, w, first + i));
    end
    tick();
    tvalid_i = 1'b0;
    tlast_i  = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    @(negedge clk_i);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_tvalid"}, 32'(m_tvalid_o), 32'd0);
  endtask

  initial begin
    arst_i = 1'b1; tdata_i = '0; tvalid_i = 1'b0; tlast_i = 1'b0; m_tready_i = 1'b0;
    set_roi(10, 13, 5, 6);
    #2;
    check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
    check("rst_tdata",  32'(m_tdata_o),  32'd0);
    check("rst_tuser",  32'(m_tuser_o),  32'd0);
    check("rst_tlast",  32'(m_tlast_o),  32'd0);
    check("rst_ovf",    32'(overflow_o), 32'd0);
`ifdef ROI_PACK_OVF_CNT_EN
    check("rst_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
`endif
    repeat (2) tick();
    arst_i = 1'b0;

    // Basic frame, W=4, always ready
    m_tready_i = 1'b1;
    send(8, 1, 4);
    drain("basic", 50);

    // Same ROI, buffered then stalled mid-row
    m_tready_i = 1'b0;
    send(8, 1, 4);
    tick(); m_tready_i = 1'b1;
    tick();
    tick(); m_tready_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("stall_tvalid", 32'(m_tvalid_o), 32'd1);
      check("stall_head", 32'({m_tlast_o, m_tuser_o, m_tdata_o}), 32'(exp_q[0]));
    end
    tick(); m_tready_i = 1'b1;
    drain("stall", 50);

    // Reversed corners still give W=4
    set_roi(20, 17, 0, 3);
    send(10, 20, 4);
    drain("reversed", 50);

    // Single-column ROI: every beat is a row end
    set_roi(7, 7, 1, 3);
    send(3, 100, 1);
    drain("w1", 50);

    // Overflow: 20 pixels into a 16-deep FIFO with no drain
    set_roi(10, 13, 5, 6);
    m_tready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tdata_i  = 8'(i + 1);
      tvalid_i = 1'b1;
      tlast_i  = (i == 19);
      if (i < 16) exp_q.push_back(mk(i, 1000, 4, i + 1));
      @(negedge clk_i);
      check("ovf_timing", 32'(overflow_o), 32'((i + 1) >= 18));
    end
    tick();
    tvalid_i = 1'b0;
    tlast_i  = 1'b0;
    @(negedge clk_i);
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_tvalid", 32'(m_tvalid_o), 32'd1);
`ifdef ROI_PACK_OVF_CNT_EN
    check("ovf_cnt", 32'(ovf_cnt_o), 32'd4);
`endif
    tick(); m_tready_i = 1'b1;
    drain("ovf", 100);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Reset with 5 pixels buffered mid-frame
    m_tready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tdata_i  = 8'(200 + i);
      tvalid_i = 1'b1;
    end
    tick();
    tvalid_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_tvalid", 32'(m_tvalid_o), 32'd1);
    #1 arst_i = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_tvalid_o), 32'd0);
    check("arst_tuser",  32'(m_tuser_o),  32'd0);
    check("arst_tdata",  32'(m_tdata_o),  32'd0);
    check("arst_ovf",    32'(overflow_o), 32'd0);
`ifdef ROI_PACK_OVF_CNT_EN
    check("arst_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
`endif
    tick();
    arst_i = 1'b0;
    m_tready_i = 1'b1;
    send(4, 50, 4);
    drain("post_rst", 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
